// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes RV32I instruction descriptors arriving on a
// valid/ready stream and writes them sequentially into instruction memory.
// While a load session runs, the core is held in reset through cpu_hold.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   load_start         opens a session (only looked at while idle)
//   in_valid/in_ready  descriptor handshake; in_last closes the session
//   in_kind            0=LW 1=SW 2=R 3=BRANCH 4=OP-IMM 5=JAL, 6/7 illegal
//   in_funct3, in_alt  funct3 and the R-type sub/sra selector
//   in_rd/rs1/rs2      register fields
//   in_imm             signed immediate (byte offset for BRANCH/JAL)
//   imem_we/addr/wdata instruction-memory write port (registered)
//   cpu_hold           high for the whole session
//   load_done          one-cycle pulse when the session closes
//   word_count         words written in the current/last session
//   err_illegal        sticky: an illegal kind was received
//   err_overflow       sticky: memory filled before in_last
module instr_encoder_loader #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [2:0]        in_kind,
   input  logic [2:0]        in_funct3,
   input  logic              in_alt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic [ADDR_W:0]   word_count,
   output logic              err_illegal,
   output logic              err_overflow
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_FINISH
   } state_t;

   localparam logic [2:0] K_LW  = 3'd0;
   localparam logic [2:0] K_SW  = 3'd1;
   localparam logic [2:0] K_R   = 3'd2;
   localparam logic [2:0] K_BR  = 3'd3;
   localparam logic [2:0] K_OPI = 3'd4;
   localparam logic [2:0] K_JAL = 3'd5;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   // Count value just before the memory is full: the next legal write
   // fills the last free word.
   localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                done_q, done_d;
   logic                ill_q, ill_d;
   logic                ovf_q, ovf_d;

   logic [31:0]         enc;
   logic                legal;
   logic [6:0]          funct7;

   // Immediate bits above 20 are never placed in any format.
   logic                unused_imm;
   assign unused_imm = ^in_imm[31:21];

   assign funct7 = in_alt ? 7'b0100000 : 7'b0000000;

   // Instruction encoder: fields a format does not use stay zero.
   always_comb begin
      enc   = '0;
      legal = 1'b1;
      unique case (in_kind)
         K_LW:
            enc = {in_imm[11:0], in_rs1, 3'b010,
                   in_rd, OP_LOAD};
         K_SW:
            enc = {in_imm[11:5], in_rs2, in_rs1,
                   3'b010, in_imm[4:0], OP_STORE};
         K_R:
            enc = {funct7, in_rs2, in_rs1,
                   in_funct3, in_rd, OP_REG};
         K_BR:
            enc = {in_imm[12], in_imm[10:5],
                   in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11],
                   OP_BRANCH};
         K_OPI:
            enc = {in_imm[11:0], in_rs1,
                   in_funct3, in_rd, OP_IMM};
         K_JAL:
            enc = {in_imm[20], in_imm[10:1],
                   in_imm[11], in_imm[19:12],
                   in_rd, OP_JAL};
         default:
            legal = 1'b0;
      endcase
   end

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      done_d  = 1'b0;
      ill_d   = ill_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         S_IDLE: begin
            if (load_start) begin
               state_d = S_LOAD;
               ptr_d   = BASE;
               cnt_d   = '0;
               ill_d   = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               if (legal) begin
                  we_d    = 1'b1;
                  addr_d  = ptr_q;
                  wdata_d = enc;
                  ptr_d   = ptr_q + 1'b1;
                  cnt_d   = cnt_q + 1'b1;
                  if (!in_last && cnt_q == LAST_CNT)
                     ovf_d = 1'b1;
               end else begin
                  ill_d = 1'b1;
               end
               if (in_last || (legal && cnt_q == LAST_CNT))
                  state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         ill_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         ill_q   <= ill_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready     = (state_q == S_LOAD);
   assign cpu_hold     = (state_q != S_IDLE);
   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign load_done    = done_q;
   assign word_count   = cnt_q;
   assign err_illegal  = ill_q;
   assign err_overflow = ovf_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed scoreboard bench for instr_encoder_loader.
// Instance A uses the default 8-bit address, instance B a 2-bit address.
module tb_instr_encoder_loader;

   typedef struct {
      logic [2:0]  kind;
      logic [2:0]  f3;
      logic        alt;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        last;
      logic [31:0] exp;
   } beat_t;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic lsA, vA, lsB, vB;
   logic last;
   logic [2:0] kind, f3;
   logic alt;
   logic [4:0] rd, rs1, rs2;
   logic [31:0] imm;

   logic rdyA, weA, holdA, doneA, illA, ovfA;
   logic [7:0] addrA;
   logic [31:0] wdA;
   logic [8:0] wcA;

   logic rdyB, weB, holdB, doneB, illB, ovfB;
   logic [1:0] addrB;
   logic [31:0] wdB;
   logic [2:0] wcB;

   int vectors = 0;
   int miscompares = 0;
   int dcA = 0;
   int dcB = 0;
   exp_t qA[$];
   exp_t qB[$];
   exp_t eA, eB;
   beat_t sess[$];

   always #5 clk = ~clk;

   instr_encoder_loader dutA (
      .clk(clk), .reset(reset), .load_start(lsA),
      .in_valid(vA), .in_ready(rdyA), .in_last(last),
      .in_kind(kind), .in_funct3(f3), .in_alt(alt),
      .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm),
      .imem_we(weA), .imem_addr(addrA), .imem_wdata(wdA),
      .cpu_hold(holdA), .load_done(doneA), .word_count(wcA),
      .err_illegal(illA), .err_overflow(ovfA)
   );

   instr_encoder_loader #(.ADDR_W(2)) dutB (
      .clk(clk), .reset(reset), .load_start(lsB),
      .in_valid(vB), .in_ready(rdyB), .in_last(last),
      .in_kind(kind), .in_funct3(f3), .in_alt(alt),
      .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm),
      .imem_we(weB), .imem_addr(addrB), .imem_wdata(wdB),
      .cpu_hold(holdB), .load_done(doneB), .word_count(wcB),
      .err_illegal(illB), .err_overflow(ovfB)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h, required %08h", nm, act, exp);
      end
   endtask

   function automatic beat_t mk(input logic [2:0] k, input logic [2:0] f,
                                input logic a, input logic [4:0] d,
                                input logic [4:0] s1, input logic [4:0] s2,
                                input logic [31:0] i, input logic l,
                                input logic [31:0] e);
      beat_t b;
      b.kind = k; b.f3 = f; b.alt = a; b.rd = d;
      b.rs1 = s1; b.rs2 = s2; b.imm = i; b.last = l; b.exp = e;
      return b;
   endfunction

   // Scoreboard monitors: every write must match the oldest expectation.
   always @(negedge clk) begin
      if (weA) begin
         if (qA.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL A_unexpected_write: addr %0h data %08h, required none",
                     addrA, wdA);
         end else begin
            eA = qA.pop_front();
            chk("A_addr", 32'(addrA), 32'(eA.addr));
            chk("A_data", wdA, eA.data);
         end
      end
      if (doneA) dcA++;
   end

   always @(negedge clk) begin
      if (weB) begin
         if (qB.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL B_unexpected_write: addr %0h data %08h, required none",
                     addrB, wdB);
         end else begin
            eB = qB.pop_front();
            chk("B_addr", 32'(addrB), 32'(eB.addr));
            chk("B_data", wdB, eB.data);
         end
      end
      if (doneB) dcB++;
   end

   task automatic drive(input bit useB, input beat_t b, input int addr);
      int n = 0;
      kind = b.kind; f3 = b.f3; alt = b.alt; rd = b.rd;
      rs1 = b.rs1; rs2 = b.rs2; imm = b.imm; last = b.last;
      if (b.kind < 3'd6) begin
         if (useB) qB.push_back('{addr, b.exp});
         else qA.push_back('{addr, b.exp});
      end
      if (useB) vB = 1'b1; else vA = 1'b1;
      while (!(useB ? rdyB : rdyA) && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (!(useB ? rdyB : rdyA)) chk("ready_timeout", 0, 1);
      else begin @(posedge clk); #1; end
      vA = 1'b0; vB = 1'b0;
   endtask

   task automatic start(input bit useB);
      if (useB) lsB = 1'b1; else lsA = 1'b1;
      @(posedge clk); #1;
      lsA = 1'b0; lsB = 1'b0;
      chk("start_hold", 32'(useB ? holdB : holdA), 1);
      chk("start_ready", 32'(useB ? rdyB : rdyA), 1);
   endtask

   task automatic play(input bit useB, input bit gapped);
      int addr = 0;
      for (int i = 0; i < sess.size(); i++) begin
         drive(useB, sess[i], addr);
         if (sess[i].kind < 3'd6) addr++;
         if (gapped && !sess[i].last) begin
            if (i == 1) lsA = 1'b1;
            chk("gap_hold", 32'(holdA), 1);
            @(posedge clk); #1;
            lsA = 1'b0;
         end
      end
   endtask

   task automatic fin(input bit useB, input int wc, input bit ill,
                      input bit ovf, input bit we);
      chk("fin_hold", 32'(useB ? holdB : holdA), 1);
      chk("fin_ready", 32'(useB ? rdyB : rdyA), 0);
      chk("fin_we", 32'(useB ? weB : weA), 32'(we));
      @(posedge clk); #1;
      chk("done", 32'(useB ? doneB : doneA), 1);
      chk("done_hold", 32'(useB ? holdB : holdA), 0);
      chk("word_count", 32'(useB ? 9'(wcB) : wcA), 32'(wc));
      chk("err_illegal", 32'(useB ? illB : illA), 32'(ill));
      chk("err_overflow", 32'(useB ? ovfB : ovfA), 32'(ovf));
      @(posedge clk); #1;
      chk("done_pulse", 32'(useB ? doneB : doneA), 0);
      chk("wc_stable", 32'(useB ? 9'(wcB) : wcA), 32'(wc));
   endtask

   task automatic chk_reset_A();
      chk("rst_ready", 32'(rdyA), 0);
      chk("rst_we", 32'(weA), 0);
      chk("rst_addr", 32'(addrA), 0);
      chk("rst_wdata", wdA, 0);
      chk("rst_hold", 32'(holdA), 0);
      chk("rst_done", 32'(doneA), 0);
      chk("rst_wc", 32'(wcA), 0);
      chk("rst_ill", 32'(illA), 0);
      chk("rst_ovf", 32'(ovfA), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int dsave;
      reset = 1'b1;
      lsA = 1'b0; vA = 1'b0; lsB = 1'b0; vB = 1'b0;
      last = 1'b0; kind = '0; f3 = '0; alt = 1'b0;
      rd = '0; rs1 = '0; rs2 = '0; imm = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_A();
      chk("rst_B_hold", 32'(holdB), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // ADDI, SUB, LW (funct3 and rs2 must be ignored for LW)
      sess.delete();
      sess.push_back(mk(4, 0, 0, 1, 0, 0, 32'd5, 0, 32'h00500093));
      sess.push_back(mk(2, 0, 1, 3, 1, 2, 32'd0, 0, 32'h402081B3));
      sess.push_back(mk(0, 7, 0, 4, 0, 31, 32'd8, 1, 32'h00802203));
      start(0); play(0, 0); fin(0, 3, 0, 0, 1);

      // SW, BEQ -4, JAL 2048 with junk in unused fields
      sess.delete();
      sess.push_back(mk(1, 5, 0, 31, 0, 5, 32'd12, 0, 32'h00502623));
      sess.push_back(mk(3, 0, 0, 31, 1, 2, 32'hFFFFFFFC, 0, 32'hFE208EE3));
      sess.push_back(mk(5, 3, 1, 1, 7, 9, 32'd2048, 1, 32'h001000EF));
      start(0); play(0, 0); fin(0, 3, 0, 0, 1);

      // Reset in the middle of a session after two writes
      start(0);
      drive(0, mk(4, 0, 0, 1, 0, 0, 32'd5, 0, 32'h00500093), 0);
      drive(0, mk(4, 0, 0, 2, 1, 0, 32'hFFFFFFFF, 0, 32'hFFF08113), 1);
      @(negedge clk); #1;
      dsave = dcA;
      reset = 1'b1;
      #1;
      chk_reset_A();
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_no_done", 32'(dcA), 32'(dsave));
      chk("rst_idle_ready", 32'(rdyA), 0);

      // Illegal kind between two ADDIs
      sess.delete();
      sess.push_back(mk(4, 0, 0, 1, 0, 0, 32'd5, 0, 32'h00500093));
      sess.push_back(mk(6, 0, 0, 9, 9, 9, 32'd77, 0, 32'h0));
      sess.push_back(mk(4, 0, 0, 2, 1, 0, 32'hFFFFFFFF, 1, 32'hFFF08113));
      start(0); play(0, 0); fin(0, 2, 1, 0, 1);

      // Illegal kind carrying in_last still closes the session
      sess.delete();
      sess.push_back(mk(4, 7, 0, 5, 5, 0, 32'h0FF, 0, 32'h0FF2F293));
      sess.push_back(mk(7, 0, 0, 0, 0, 0, 32'd0, 1, 32'h0));
      start(0); play(0, 0); fin(0, 1, 1, 0, 0);

      // Gapped valid with a stray load_start; flags cleared by new start
      sess.delete();
      sess.push_back(mk(4, 7, 0, 5, 5, 0, 32'h0FF, 0, 32'h0FF2F293));
      sess.push_back(mk(2, 0, 0, 3, 1, 2, 32'd0, 0, 32'h002081B3));
      sess.push_back(mk(2, 5, 1, 6, 7, 8, 32'd0, 0, 32'h4083D333));
      sess.push_back(mk(3, 1, 0, 31, 3, 4, 32'h801, 0, 32'h004190E3));
      sess.push_back(mk(5, 0, 0, 0, 3, 3, 32'hFFFFFFFE, 0, 32'hFFFFF06F));
      sess.push_back(mk(1, 0, 0, 31, 2, 1, 32'hFFFFFFF8, 1, 32'hFE112C23));
      start(0); play(0, 1); fin(0, 6, 0, 0, 1);

      // Overflow on the 4-word instance: fifth beat never accepted
      sess.delete();
      sess.push_back(mk(4, 0, 0, 1, 0, 0, 32'd1, 0, 32'h00100093));
      sess.push_back(mk(4, 0, 0, 1, 0, 0, 32'd2, 0, 32'h00200093));
      sess.push_back(mk(4, 0, 0, 1, 0, 0, 32'd3, 0, 32'h00300093));
      sess.push_back(mk(4, 0, 0, 1, 0, 0, 32'd4, 0, 32'h00400093));
      start(1); play(1, 0);
      kind = 3'd4; rd = 5'd1; imm = 32'd5; last = 1'b0;
      vB = 1'b1;
      fin(1, 4, 0, 1, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("ovf_idle_ready", 32'(rdyB), 0);
      vB = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("A_queue_empty", 32'(qA.size()), 0);
      chk("B_queue_empty", 32'(qB.size()), 0);
      chk("A_done_count", 32'(dcA), 5);
      chk("B_done_count", 32'(dcB), 1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
